multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_pkg.sv | 47 ++++
 rtl/opcode_class_decoder.sv | 48 ++++
 rtl/multicycle_control_unit.sv | 153 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants and types for the multicycle control FSM:
// state codes, opcode class patterns, ALU-op selectors, select bundle.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE,
        CL_LOAD_S,
        CL_LOAD_U,
        CL_STORE,
        CL_BRANCH,
        CL_IMM,
        CL_JUMP,
        CL_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE  = 6'b0000??;
    localparam logic [5:0] OP_LOAD_S = 6'b1000??;
    localparam logic [5:0] OP_LOAD_U = 6'b1001??;
    localparam logic [5:0] OP_STORE  = 6'b1010??;
    localparam logic [5:0] OP_BRANCH = 6'b1011??;
    localparam logic [5:0] OP_IMM    = 6'b111???;
    localparam logic [5:0] OP_JUMP   = 6'b11001?;
    localparam logic [5:0] OP_JREG   = 6'b01100?;

    localparam logic [1:0] ALU_RTYPE  = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_BRANCH = 2'b10;

    typedef struct packed {
        logic       addr_src;
        logic       data_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       signed_op;
        logic       imm;
    } ctrl_sel_t;

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier producing the class and the
// datapath select bundle that goes with it.
module opcode_class_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output ctrl_sel_t  sel
);

    always_comb begin
        op_class = CL_ILLEGAL;
        sel      = '0;
        unique casez (opcode)
            OP_RTYPE: begin
                op_class = CL_RTYPE;
                sel = '{1'b1, 1'b0, 1'b0, ALU_RTYPE, 1'b0, 1'b0};
            end
            OP_LOAD_S: begin
                op_class = CL_LOAD_S;
                sel = '{1'b0, 1'b1, 1'b1, ALU_ADD, 1'b1, 1'b0};
            end
            OP_LOAD_U: begin
                op_class = CL_LOAD_U;
                sel = '{1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b0};
            end
            OP_STORE: begin
                op_class = CL_STORE;
                sel = '{1'b0, 1'b1, 1'b1, ALU_ADD, 1'b1, 1'b0};
            end
            OP_BRANCH: begin
                op_class = CL_BRANCH;
                sel = '{1'b0, 1'b1, 1'b0, ALU_BRANCH, 1'b0, 1'b0};
            end
            OP_IMM: begin
                op_class = CL_IMM;
                sel = '{1'b0, 1'b0, 1'b1, ALU_RTYPE, 1'b1, 1'b1};
            end
            OP_JUMP, OP_JREG: begin
                op_class = CL_JUMP;
            end
            default: begin
                op_class = CL_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with bounded memory wait and sticky illegal / memory-timeout flags.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int NB_OPCODE     = 6,
    parameter int NB_ALU_OP_SEL = 2,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_halt,
    input  logic [NB_OPCODE-1:0]     i_instruction_type,
    input  logic                     i_mem_ack,
    output logic                     o_pc_enb,
    output logic                     o_ir_enb,
    output logic                     o_rf_wr_addr_src,
    output logic                     o_rf_wr_data_src,
    output logic                     o_alu_data_src,
    output logic                     o_signed_operation,
    output logic                     o_inmediate_operation,
    output logic [NB_ALU_OP_SEL-1:0] o_alu_operation,
    output logic                     o_rf_wr_enb,
    output logic                     o_data_mem_rd_enb,
    output logic                     o_data_mem_wr_enb,
    output logic                     o_branch,
    output logic                     o_jump,
    output logic                     o_busy,
    output logic                     o_instr_done,
    output logic                     o_illegal,
    output logic                     o_mem_error,
    output logic [2:0]               o_state
);

    localparam int NB_CNT = $clog2(MEM_TIMEOUT + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(MEM_TIMEOUT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [NB_OPCODE-1:0] opcode_q;
    logic [NB_CNT-1:0]    mem_cnt;
    ctrl_sel_t            sel_q;
    ctrl_sel_t            dec_sel;
    op_class_t            dec_class;
    logic                 illegal_q;
    logic                 mem_error_q;
    logic                 is_load;
    logic                 is_store;
    logic                 retire;
    logic                 mem_timeout;

    opcode_class_decoder u_decoder (
        .opcode   (opcode_q[5:0]),
        .op_class (dec_class),
        .sel      (dec_sel)
    );

    assign is_load  = (dec_class == CL_LOAD_S) || (dec_class == CL_LOAD_U);
    assign is_store = (dec_class == CL_STORE);

    // Store retires straight out of MEM on the ack cycle
    assign retire =
        (state == ST_WRITEBACK) ||
        (state == ST_DECODE  && dec_class == CL_JUMP) ||
        (state == ST_EXECUTE && dec_class == CL_BRANCH) ||
        (state == ST_MEM && is_store && i_mem_ack);

    assign mem_timeout = (state == ST_MEM) && !i_mem_ack &&
                         (mem_cnt == CNT_LAST);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_start && !illegal_q && !mem_error_q)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH:     state_nxt = ST_DECODE;
            ST_DECODE: begin
                state_nxt = (dec_class == CL_ILLEGAL) ? ST_IDLE
                                                      : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_nxt = (is_load || is_store) ? ST_MEM
                                                  : ST_WRITEBACK;
            end
            ST_MEM: begin
                if (i_mem_ack)
                    state_nxt = ST_WRITEBACK;
                else if (mem_timeout)
                    state_nxt = ST_IDLE;
            end
            ST_WRITEBACK: state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (retire)
            state_nxt = (i_start && !i_halt) ? ST_FETCH : ST_IDLE;
    end

    always_comb begin
        o_pc_enb          = (state == ST_FETCH);
        o_ir_enb          = (state == ST_FETCH);
        o_jump            = (state == ST_DECODE) &&
                            (dec_class == CL_JUMP);
        o_branch          = (state == ST_EXECUTE) &&
                            (dec_class == CL_BRANCH);
        o_data_mem_rd_enb = (state == ST_MEM) && is_load;
        o_data_mem_wr_enb = (state == ST_MEM) && is_store;
        o_rf_wr_enb       = (state == ST_WRITEBACK);
        o_busy            = (state != ST_IDLE);
        o_instr_done      = retire;
        o_state           = state;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            opcode_q    <= '0;
            sel_q       <= '0;
            mem_cnt     <= '0;
            illegal_q   <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            if (state == ST_FETCH)
                opcode_q <= i_instruction_type;
            if (state == ST_DECODE)
                sel_q <= dec_sel;
            mem_cnt <= (state == ST_MEM) ? mem_cnt + 1'b1 : '0;
            if (state == ST_DECODE && dec_class == CL_ILLEGAL)
                illegal_q <= 1'b1;
            if (mem_timeout)
                mem_error_q <= 1'b1;
        end
    end

    assign o_rf_wr_addr_src      = sel_q.addr_src;
    assign o_rf_wr_data_src      = sel_q.data_src;
    assign o_alu_data_src        = sel_q.alu_src;
    assign o_alu_operation       = NB_ALU_OP_SEL'(sel_q.alu_op);
    assign o_signed_operation    = sel_q.signed_op;
    assign o_inmediate_operation = sel_q.imm;
    assign o_illegal             = illegal_q;
    assign o_mem_error           = mem_error_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against a
// transaction-level model of each instruction's cycle sequence.
module tb_multicycle_control_unit;

    localparam int TMO = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       pc;
        logic       ir;
        logic [6:0] sel;
        logic       rf;
        logic       rd;
        logic       wr;
        logic       br;
        logic       jp;
        logic       busy;
        logic       done;
        logic       ill;
        logic       merr;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic       i_halt;
    logic [5:0] i_instruction_type;
    logic       i_mem_ack;
    logic       o_pc_enb, o_ir_enb;
    logic       o_rf_wr_addr_src, o_rf_wr_data_src, o_alu_data_src;
    logic       o_signed_operation, o_inmediate_operation;
    logic [1:0] o_alu_operation;
    logic       o_rf_wr_enb, o_data_mem_rd_enb, o_data_mem_wr_enb;
    logic       o_branch, o_jump, o_busy, o_instr_done;
    logic       o_illegal, o_mem_error;
    logic [2:0] o_state;

    multicycle_control_unit #(
        .NB_OPCODE     (6),
        .NB_ALU_OP_SEL (2),
        .MEM_TIMEOUT   (TMO)
    ) dut (
        .i_clock               (clk),
        .i_reset               (i_reset),
        .i_start               (i_start),
        .i_halt                (i_halt),
        .i_instruction_type    (i_instruction_type),
        .i_mem_ack             (i_mem_ack),
        .o_pc_enb              (o_pc_enb),
        .o_ir_enb              (o_ir_enb),
        .o_rf_wr_addr_src      (o_rf_wr_addr_src),
        .o_rf_wr_data_src      (o_rf_wr_data_src),
        .o_alu_data_src        (o_alu_data_src),
        .o_signed_operation    (o_signed_operation),
        .o_inmediate_operation (o_inmediate_operation),
        .o_alu_operation       (o_alu_operation),
        .o_rf_wr_enb           (o_rf_wr_enb),
        .o_data_mem_rd_enb     (o_data_mem_rd_enb),
        .o_data_mem_wr_enb     (o_data_mem_wr_enb),
        .o_branch              (o_branch),
        .o_jump                (o_jump),
        .o_busy                (o_busy),
        .o_instr_done          (o_instr_done),
        .o_illegal             (o_illegal),
        .o_mem_error           (o_mem_error),
        .o_state               (o_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_rd = 0, n_wr = 0, n_rf = 0, n_br = 0, n_jp = 0, n_done = 0;

    // model state: held selects and sticky flags
    logic [6:0] m_sel = '0;
    bit m_ill = 0;
    bit m_err = 0;

    // 0 RTYPE 1 IMM 2 LOAD_S 3 LOAD_U 4 STORE 5 BRANCH 6 JUMP 7 ILLEGAL
    function automatic int cls_of(input logic [5:0] op);
        int v;
        v = int'(op);
        if (v < 4) return 0;
        if (v >= 56) return 1;
        if (v >= 32 && v < 36) return 2;
        if (v >= 36 && v < 40) return 3;
        if (v >= 40 && v < 44) return 4;
        if (v >= 44 && v < 48) return 5;
        if (v == 50 || v == 51 || v == 24 || v == 25) return 6;
        return 7;
    endfunction

    // {addr_src, data_src, alu_src, alu_op[1:0], signed, imm}
    function automatic logic [6:0] sel_of(input int c);
        case (c)
            0: return 7'b1_0_0_00_0_0;
            1: return 7'b0_0_1_00_1_1;
            2: return 7'b0_1_1_01_1_0;
            3: return 7'b0_1_1_01_0_0;
            4: return 7'b0_1_1_01_1_0;
            5: return 7'b0_1_0_10_0_0;
            default: return 7'b0;
        endcase
    endfunction

    function automatic exp_t base(input int s);
        exp_t e;
        e = '0;
        e.st = 3'(s);
        e.busy = (s != 0);
        e.sel = m_sel;
        e.ill = m_ill;
        e.merr = m_err;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t g;
        g = {o_state, o_pc_enb, o_ir_enb, o_rf_wr_addr_src,
             o_rf_wr_data_src, o_alu_data_src, o_alu_operation,
             o_signed_operation, o_inmediate_operation,
             o_rf_wr_enb, o_data_mem_rd_enb, o_data_mem_wr_enb,
             o_branch, o_jump, o_busy, o_instr_done,
             o_illegal, o_mem_error};
        return g;
    endfunction

    // compare point: every cycle, on the falling edge
    task automatic tick(input exp_t e);
        exp_t g;
        @(negedge clk);
        g = sample();
        cyc++;
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL cycle %0d outputs got %h exp %h",
                     cyc, g, e);
        end
        n_rd += int'(g.rd);
        n_wr += int'(g.wr);
        n_rf += int'(g.rf);
        n_br += int'(g.br);
        n_jp += int'(g.jp);
        n_done += int'(g.done);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic noise();
        i_start   = 1'($urandom_range(0, 1));
        i_halt    = 1'($urandom_range(0, 1));
        i_mem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input bit s, output bit nf);
        i_start   = s;
        i_halt    = 1'b0;
        i_mem_ack = 1'($urandom_range(0, 1));
        tick(base(0));
        nf = s && !m_ill && !m_err;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        i_start = 1'($urandom_range(0, 1));
        tick(base(0));
        m_sel = '0;
        m_ill = 0;
        m_err = 0;
        i_reset = 1'b1;
    endtask

    // One instruction from its FETCH cycle; nmem = MEM cycle carrying
    // the ack (0 = never), st/hl = start/halt seen at retire.
    task automatic issue(input logic [5:0] op, input int nmem,
                         input bit st, input bit hl, input bit rst_mem,
                         output bit nf, output int lat);
        int c;
        int n;
        exp_t e;
        bit ack;
        bit ld;
        bit sto;
        c = cls_of(op);
        n = 0;
        nf = 0;
        lat = 0;
        ld = (c == 2 || c == 3);
        sto = (c == 4);
        i_instruction_type = op;
        noise();
        e = base(1);
        e.pc = 1;
        e.ir = 1;
        tick(e);
        n++;
        noise();
        e = base(2);
        if (c == 6) begin
            e.jp = 1;
            e.done = 1;
            i_start = st;
            i_halt = hl;
        end
        tick(e);
        n++;
        m_sel = sel_of(c);
        if (c == 6) begin
            lat = n;
            nf = st && !hl;
            return;
        end
        if (c == 7) begin
            m_ill = 1;
            return;
        end
        noise();
        e = base(3);
        if (c == 5) begin
            e.br = 1;
            e.done = 1;
            i_start = st;
            i_halt = hl;
        end
        tick(e);
        n++;
        if (c == 5) begin
            lat = n;
            nf = st && !hl;
            return;
        end
        if (ld || sto) begin
            for (int k = 1; k <= TMO; k++) begin
                noise();
                ack = (k == nmem);
                i_mem_ack = ack;
                e = base(4);
                e.rd = ld;
                e.wr = sto;
                if (rst_mem && k == 2) begin
                    i_mem_ack = 1'b0;
                    i_reset = 1'b0;
                    tick(e);
                    m_sel = '0;
                    m_ill = 0;
                    m_err = 0;
                    i_reset = 1'b1;
                    return;
                end
                if (sto && ack) begin
                    e.done = 1;
                    i_start = st;
                    i_halt = hl;
                end
                tick(e);
                n++;
                if (ack) begin
                    if (sto) begin
                        lat = n;
                        nf = st && !hl;
                        return;
                    end
                    break;
                end
                if (k == TMO) begin
                    m_err = 1;
                    return;
                end
            end
        end
        noise();
        e = base(5);
        e.rf = 1;
        e.done = 1;
        i_start = st;
        i_halt = hl;
        tick(e);
        n++;
        lat = n;
        nf = st && !hl;
    endtask

    int bases [8] = '{0, 56, 32, 36, 40, 44, 50, 24};
    int spans [8] = '{4, 8, 4, 4, 4, 4, 2, 2};

    initial begin
        bit nf;
        int lat;
        int lat2;
        int s_rd, s_wr, s_rf, s_br, s_jp, s_done;
        logic [5:0] op;
        int nmem;
        int j;

        i_reset = 1'b0;
        i_start = 1'b0;
        i_halt = 1'b0;
        i_mem_ack = 1'b0;
        i_instruction_type = '0;
        repeat (2) @(posedge clk);
        #1;
        tick(base(0));
        i_reset = 1'b1;

        // RTYPE: FETCH, DECODE, EXECUTE, WRITEBACK
        idle(1, nf);
        s_rf = n_rf;
        issue(6'b000000, 0, 0, 0, 0, nf, lat);
        lit("rtype_latency", lat, 4);
        lit("rtype_rf_wr_cycles", n_rf - s_rf, 1);
        lit("rtype_addr_src", int'(o_rf_wr_addr_src), 1);

        // signed load, ack in third MEM cycle
        idle(1, nf);
        s_rd = n_rd;
        s_rf = n_rf;
        issue(6'b100011, 3, 0, 0, 0, nf, lat);
        lit("load_latency", lat, 7);
        lit("load_rd_cycles", n_rd - s_rd, 3);
        lit("load_rf_wr_cycles", n_rf - s_rf, 1);
        lit("load_signed", int'(o_signed_operation), 1);

        // store with no ack: timeout
        idle(1, nf);
        s_wr = n_wr;
        s_rf = n_rf;
        issue(6'b101011, 0, 1, 0, 0, nf, lat);
        lit("store_to_wr_cycles", n_wr - s_wr, 4);
        lit("store_to_rf_wr", n_rf - s_rf, 0);
        lit("store_to_mem_error", int'(o_mem_error), 1);
        idle(1, nf);
        idle(1, nf);
        lit("start_ignored_state", int'(o_state), 0);
        do_reset();

        // illegal opcode
        idle(1, nf);
        s_rd = n_rd; s_wr = n_wr; s_rf = n_rf;
        s_br = n_br; s_jp = n_jp; s_done = n_done;
        issue(6'b010101, 0, 0, 0, 0, nf, lat);
        lit("illegal_flag", int'(o_illegal), 1);
        lit("illegal_state", int'(o_state), 0);
        lit("illegal_strobes",
            (n_rd - s_rd) + (n_wr - s_wr) + (n_rf - s_rf) +
            (n_br - s_br) + (n_jp - s_jp) + (n_done - s_done), 0);
        idle(0, nf);
        do_reset();

        // branch then jump back to back, halt at second retire
        idle(1, nf);
        s_br = n_br; s_jp = n_jp; s_done = n_done;
        issue(6'b101100, 0, 1, 0, 0, nf, lat);
        issue(6'b110010, 0, 1, 1, 0, nf, lat2);
        lit("branch_latency", lat, 3);
        lit("jump_latency", lat2, 2);
        lit("branch_cycles", n_br - s_br, 1);
        lit("jump_cycles", n_jp - s_jp, 1);
        lit("done_pulses", n_done - s_done, 2);
        lit("halt_state", int'(o_state), 0);

        // reset while waiting in MEM
        idle(1, nf);
        issue(6'b100000, 0, 0, 0, 1, nf, lat);
        lit("rst_mem_outputs", int'(sample()), 0);
        idle(0, nf);

        nf = 0;
        for (int i = 0; i < 200; i++) begin
            if (!nf) begin
                repeat ($urandom_range(0, 2)) idle(0, nf);
                if (m_ill || m_err)
                    do_reset();
                idle(1, nf);
            end
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom_range(0, 63));
            end else begin
                j = $urandom_range(0, 7);
                op = 6'(bases[j] + $urandom_range(0, spans[j] - 1));
            end
            nmem = ($urandom_range(0, 9) == 0) ? 0
                                               : $urandom_range(1, TMO);
            issue(op, nmem, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, 0, nf, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
